// File: rtl/led_pio_pkg.sv
// Shared definitions for the LED PIO with set/clear/toggle, blink and PWM.
// Holds the register word addresses and the PWM counter and brightness constants.
package led_pio_pkg;

   localparam logic [2:0] ADDR_DATA     = 3'd0;
   localparam logic [2:0] ADDR_SET      = 3'd1;
   localparam logic [2:0] ADDR_CLEAR    = 3'd2;
   localparam logic [2:0] ADDR_TOGGLE   = 3'd3;
   localparam logic [2:0] ADDR_BLINK_EN = 3'd4;
   localparam logic [2:0] ADDR_PERIOD   = 3'd5;
   localparam logic [2:0] ADDR_BRIGHT   = 3'd6;
   localparam logic [2:0] ADDR_STATUS   = 3'd7;

   localparam int unsigned BRIGHT_W = 8;

   // The PWM counter runs 0..PWM_MAX, so the full PWM period is 255 clocks.
   // Duty 255 is therefore always on and duty 0 is always off.
   localparam logic [BRIGHT_W-1:0] PWM_MAX    = 8'd254;
   localparam logic [BRIGHT_W-1:0] BRIGHT_RST = 8'd255;

endpackage

// File: rtl/led_blink_timer.sv
// Blink phase generator.
// A prescaler divides clk down to a one-cycle tick every PRESCALE clocks; a
// blink counter toggles phase every 'period' ticks.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   period     : blink half-period in ticks (0 disables blinking, phase held 1)
//   restart    : clears prescaler and blink counter and forces phase to 1
//   phase      : current blink phase (1 = LEDs shown)
module led_blink_timer #(
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [PERIOD_W-1:0] period,
   input  logic                restart,
   output logic                phase
);

   localparam int unsigned PRESC_W = $clog2(PRESCALE);
   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PERIOD_W-1:0] blink_cnt_q, blink_cnt_d;
   logic                phase_q, phase_d;
   logic                tick;

   always_comb begin
      tick        = (presc_q == PRESC_MAX);
      presc_d     = tick ? '0 : presc_q + 1'b1;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;

      // Restart has priority over a coincident tick/toggle so that the next
      // toggle is a full PRESCALE*period clocks after the restart.
      if (restart) begin
         presc_d     = '0;
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (period == '0) begin
         blink_cnt_d = '0;
         phase_d     = 1'b1;
      end else if (tick) begin
         if (blink_cnt_q == period - 1'b1) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q     <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b1;
      end else begin
         presc_q     <= presc_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/led_pio_pwm.sv
// Avalon-MM LED output port with atomic set/clear/toggle, per-bit blink and
// global PWM brightness. Zero-wait-state slave, combinational read data.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   chipselect : slave select
//   write_n    : active-low write strobe
//   address    : word address (DATA, SET, CLEAR, TOGGLE, BLINK_EN, PERIOD,
//                BRIGHT, STATUS)
//   writedata  : write data, bits above each register's width ignored
//   readdata   : read data, 0 when not selected
//   out_port   : registered LED drive
module led_pio_pwm
   import led_pio_pkg::*;
#(
   parameter int unsigned WIDTH    = 27,
   parameter int unsigned PRESCALE = 50000,
   parameter int unsigned PERIOD_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [2:0]       address,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   logic [WIDTH-1:0]    data_q, data_d;
   logic [WIDTH-1:0]    blink_en_q, blink_en_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [BRIGHT_W-1:0] bright_q, bright_d;
   logic [BRIGHT_W-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [WIDTH-1:0]    out_q, out_d;

   logic                wr_en;
   logic                restart;
   logic                phase;
   logic                pwm_on;
   logic [WIDTH-1:0]    wd_led;
   logic                unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign wd_led    = writedata[WIDTH-1:0];
   assign restart   = wr_en && (address == ADDR_PERIOD);
   assign unused_wd = ^writedata;

   led_blink_timer #(
      .PRESCALE (PRESCALE),
      .PERIOD_W (PERIOD_W)
   ) u_blink_timer (
      .clk     (clk),
      .reset   (reset),
      .period  (period_q),
      .restart (restart),
      .phase   (phase)
   );

   // Register file next state; SET/CLEAR/TOGGLE are single-cycle RMW on DATA.
   always_comb begin
      data_d     = data_q;
      blink_en_d = blink_en_q;
      period_d   = period_q;
      bright_d   = bright_q;
      if (wr_en) begin
         case (address)
            ADDR_DATA:     data_d     = wd_led;
            ADDR_SET:      data_d     = data_q | wd_led;
            ADDR_CLEAR:    data_d     = data_q & ~wd_led;
            ADDR_TOGGLE:   data_d     = data_q ^ wd_led;
            ADDR_BLINK_EN: blink_en_d = wd_led;
            ADDR_PERIOD:   period_d   = writedata[PERIOD_W-1:0];
            ADDR_BRIGHT:   bright_d   = writedata[BRIGHT_W-1:0];
            default:       ;
         endcase
      end
   end

   // PWM and output stage.
   always_comb begin
      pwm_cnt_d = (pwm_cnt_q == PWM_MAX) ? '0 : pwm_cnt_q + 1'b1;
      pwm_on    = (pwm_cnt_q < bright_q);
      out_d     = data_q & (~blink_en_q | {WIDTH{phase}}) & {WIDTH{pwm_on}};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= '0;
         blink_en_q <= '0;
         period_q   <= '0;
         bright_q   <= BRIGHT_RST;
         pwm_cnt_q  <= '0;
         out_q      <= '0;
      end else begin
         data_q     <= data_d;
         blink_en_q <= blink_en_d;
         period_q   <= period_d;
         bright_q   <= bright_d;
         pwm_cnt_q  <= pwm_cnt_d;
         out_q      <= out_d;
      end
   end

   assign out_port = out_q;

   // Read mux; SET/CLEAR/TOGGLE addresses read back DATA.
   always_comb begin
      readdata = '0;
      if (chipselect) begin
         case (address)
            ADDR_DATA,
            ADDR_SET,
            ADDR_CLEAR,
            ADDR_TOGGLE:   readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_BRIGHT:   readdata = 32'(bright_q);
            ADDR_STATUS: begin
               readdata[8]   = phase;
               readdata[7:0] = pwm_cnt_q;
            end
            default:       readdata = '0;
         endcase
      end
   end

endmodule
